// File: rtl/ysyx_23060208_ifu_fetch_pkg.sv
// Shared definitions for the instruction-fetch initiator: FSM encoding,
// AXI-lite response code and the default boot address.
package ysyx_23060208_ifu_fetch_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_AR   = 2'd1,
    ST_R    = 2'd2,
    ST_HOLD = 2'd3
  } fetch_state_e;

  localparam logic [1:0]  RESP_OKAY        = 2'b00;
  localparam logic [31:0] DEFAULT_RESET_PC = 32'h8000_0000;

endpackage

// File: rtl/ysyx_23060208_ifu_fetch.sv
// Instruction-fetch read initiator: one AR/R read per instruction, a one-entry
// instruction buffer toward the IDU, and redirect handling during in-flight reads.
module ysyx_23060208_ifu_fetch
  import ysyx_23060208_ifu_fetch_pkg::*;
#(
  parameter int                    DATA_WIDTH = 32,
  parameter logic [DATA_WIDTH-1:0] RESET_PC   = DATA_WIDTH'(DEFAULT_RESET_PC)
) (
  input  logic                  clk,
  input  logic                  rst,
  output logic [DATA_WIDTH-1:0] ifu_araddr,
  output logic                  ifu_arvalid,
  input  logic                  ifu_arready,
  input  logic [1:0]            ifu_rresp,
  input  logic                  ifu_rvalid,
  input  logic [DATA_WIDTH-1:0] ifu_rdata,
  output logic                  ifu_rready,
  output logic                  ifu_to_idu_valid,
  output logic [DATA_WIDTH-1:0] ifu_to_idu_inst,
  output logic [DATA_WIDTH-1:0] ifu_to_idu_pc,
  output logic                  ifu_to_idu_err,
  input  logic                  idu_allowin,
  input  logic                  exu_redirect_valid,
  input  logic [DATA_WIDTH-1:0] exu_redirect_pc
);

  fetch_state_e          state_q;
  logic [DATA_WIDTH-1:0] pc_q;
  logic [DATA_WIDTH-1:0] redirect_pc_q;
  logic [DATA_WIDTH-1:0] inst_q;
  logic                  flush_pending_q;
  logic                  err_q;
  logic                  arvalid_q;
  logic                  rready_q;

  logic [DATA_WIDTH-1:0] pc_plus4;
  logic                  flush_now;
  logic [DATA_WIDTH-1:0] flush_target;

  assign pc_plus4 = pc_q + DATA_WIDTH'(4);

  // A redirect arriving in the same cycle as the response is treated as the newest target.
  assign flush_now    = flush_pending_q | exu_redirect_valid;
  assign flush_target = exu_redirect_valid ? exu_redirect_pc : redirect_pc_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q         <= ST_IDLE;
      pc_q            <= RESET_PC;
      redirect_pc_q   <= RESET_PC;
      inst_q          <= '0;
      flush_pending_q <= 1'b0;
      err_q           <= 1'b0;
      arvalid_q       <= 1'b0;
      rready_q        <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (exu_redirect_valid) begin
            pc_q <= exu_redirect_pc;
          end
          state_q   <= ST_AR;
          arvalid_q <= 1'b1;
        end

        ST_AR: begin
          // The request stays on the bus; a redirect only marks its response for discard.
          if (exu_redirect_valid) begin
            redirect_pc_q   <= exu_redirect_pc;
            flush_pending_q <= 1'b1;
          end
          if (ifu_arready) begin
            state_q   <= ST_R;
            arvalid_q <= 1'b0;
            rready_q  <= 1'b1;
          end
        end

        ST_R: begin
          if (ifu_rvalid) begin
            rready_q <= 1'b0;
            if (flush_now) begin
              pc_q            <= flush_target;
              flush_pending_q <= 1'b0;
              state_q         <= ST_AR;
              arvalid_q       <= 1'b1;
            end else begin
              inst_q  <= ifu_rdata;
              err_q   <= (ifu_rresp != RESP_OKAY);
              state_q <= ST_HOLD;
            end
          end else if (exu_redirect_valid) begin
            redirect_pc_q   <= exu_redirect_pc;
            flush_pending_q <= 1'b1;
          end
        end

        ST_HOLD: begin
          if (exu_redirect_valid) begin
            pc_q      <= exu_redirect_pc;
            state_q   <= ST_AR;
            arvalid_q <= 1'b1;
          end else if (idu_allowin) begin
            pc_q      <= pc_plus4;
            state_q   <= ST_AR;
            arvalid_q <= 1'b1;
          end
        end

        default: begin
          state_q   <= ST_IDLE;
          arvalid_q <= 1'b0;
          rready_q  <= 1'b0;
        end
      endcase
    end
  end

  assign ifu_araddr       = pc_q;
  assign ifu_arvalid      = arvalid_q;
  assign ifu_rready       = rready_q;
  assign ifu_to_idu_valid = (state_q == ST_HOLD) & ~exu_redirect_valid;
  assign ifu_to_idu_inst  = inst_q;
  assign ifu_to_idu_pc    = pc_q;
  assign ifu_to_idu_err   = err_q;

endmodule

// File: tb/tb_ysyx_23060208_ifu_fetch.sv
// Directed bench for the fetch initiator with a small SRAM slave model
// whose AR and R latencies are set per test.
module tb_ysyx_23060208_ifu_fetch;

  localparam logic [31:0] RST_PC = 32'h8000_0000;

  logic        clk;
  logic        rst;
  logic [31:0] ifu_araddr;
  logic        ifu_arvalid;
  logic        ifu_arready;
  logic [1:0]  ifu_rresp;
  logic        ifu_rvalid;
  logic [31:0] ifu_rdata;
  logic        ifu_rready;
  logic        ifu_to_idu_valid;
  logic [31:0] ifu_to_idu_inst;
  logic [31:0] ifu_to_idu_pc;
  logic        ifu_to_idu_err;
  logic        idu_allowin;
  logic        exu_redirect_valid;
  logic [31:0] exu_redirect_pc;

  int checks   = 0;
  int failures = 0;

  int         ar_stall_cfg = 0;
  int         r_stall_cfg  = 0;
  logic [1:0] resp_cfg     = 2'b00;

  ysyx_23060208_ifu_fetch #(
    .DATA_WIDTH(32),
    .RESET_PC  (RST_PC)
  ) dut (
    .clk               (clk),
    .rst               (rst),
    .ifu_araddr        (ifu_araddr),
    .ifu_arvalid       (ifu_arvalid),
    .ifu_arready       (ifu_arready),
    .ifu_rresp         (ifu_rresp),
    .ifu_rvalid        (ifu_rvalid),
    .ifu_rdata         (ifu_rdata),
    .ifu_rready        (ifu_rready),
    .ifu_to_idu_valid  (ifu_to_idu_valid),
    .ifu_to_idu_inst   (ifu_to_idu_inst),
    .ifu_to_idu_pc     (ifu_to_idu_pc),
    .ifu_to_idu_err    (ifu_to_idu_err),
    .idu_allowin       (idu_allowin),
    .exu_redirect_valid(exu_redirect_valid),
    .exu_redirect_pc   (exu_redirect_pc)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // SRAM content: a fixed scramble of the address.
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return a ^ 32'h1234_5678;
  endfunction

  // Slave model, driven on the falling edge.
  int          ar_wait = 0;
  int          r_wait  = 0;
  logic [31:0] rd_addr = '0;
  always @(negedge clk) begin
    if (!rst) begin
      ifu_arready = 1'b0;
      ifu_rvalid  = 1'b0;
      ifu_rdata   = '0;
      ifu_rresp   = 2'b00;
      ar_wait     = 0;
      r_wait      = 0;
    end else begin
      if (ifu_rready) begin
        if (r_wait >= r_stall_cfg) begin
          ifu_rvalid = 1'b1;
          ifu_rdata  = mem_word(rd_addr);
          ifu_rresp  = resp_cfg;
          r_wait     = 0;
        end else begin
          ifu_rvalid = 1'b0;
          r_wait     = r_wait + 1;
        end
      end else begin
        ifu_rvalid = 1'b0;
        r_wait     = 0;
      end
      if (ifu_arvalid) begin
        if (ar_wait >= ar_stall_cfg) begin
          ifu_arready = 1'b1;
          rd_addr     = ifu_araddr;
          ar_wait     = 0;
        end else begin
          ifu_arready = 1'b0;
          ar_wait     = ar_wait + 1;
        end
      end else begin
        ifu_arready = 1'b0;
        ar_wait     = 0;
      end
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_arvalid"}, 32'(ifu_arvalid), 32'd0);
    check({tag, "_rready"},  32'(ifu_rready), 32'd0);
    check({tag, "_valid"},   32'(ifu_to_idu_valid), 32'd0);
    check({tag, "_err"},     32'(ifu_to_idu_err), 32'd0);
    check({tag, "_araddr"},  ifu_araddr, RST_PC);
    check({tag, "_pc"},      ifu_to_idu_pc, RST_PC);
    check({tag, "_inst"},    ifu_to_idu_inst, 32'd0);
  endtask

  // Starts in AR for exp_pc; returns in HOLD with the buffered instruction checked.
  task automatic do_fetch(input logic [31:0] exp_pc, input logic exp_err, output int cyc);
    int n;
    check("fetch_arvalid", 32'(ifu_arvalid), 32'd1);
    check("fetch_araddr", ifu_araddr, exp_pc);
    n = 0;
    while (!ifu_to_idu_valid && n < 40) begin
      tick();
      n++;
    end
    check("fetch_valid", 32'(ifu_to_idu_valid), 32'd1);
    cyc = n;
    check("fetch_inst", ifu_to_idu_inst, mem_word(exp_pc));
    check("fetch_pc", ifu_to_idu_pc, exp_pc);
    check("fetch_err", 32'(ifu_to_idu_err), 32'(exp_err));
    $display("fetch pc=%h inst=%h err=%0d cycles=%0d", ifu_to_idu_pc, ifu_to_idu_inst,
             ifu_to_idu_err, n);
  endtask

  // Waits for the next AR request, noting whether any instruction leaked to the IDU.
  task automatic wait_next_ar(input string tag, input logic [31:0] exp_addr);
    int   n;
    logic leaked;
    n = 0;
    leaked = 1'b0;
    while (!ifu_arvalid && n < 40) begin
      if (ifu_to_idu_valid) leaked = 1'b1;
      tick();
      n++;
    end
    check({tag, "_no_valid"}, 32'(leaked), 32'd0);
    check({tag, "_arvalid"}, 32'(ifu_arvalid), 32'd1);
    check({tag, "_araddr"}, ifu_araddr, exp_addr);
  endtask

  initial begin
    int          cyc;
    int          n;
    logic [31:0] held_inst;

    rst                = 1'b0;
    idu_allowin        = 1'b1;
    exu_redirect_valid = 1'b0;
    exu_redirect_pc    = '0;
    repeat (3) tick();
    check_reset_values("reset");

    // Release: one IDLE cycle, then the request.
    rst = 1'b1;
    check("idle_arvalid", 32'(ifu_arvalid), 32'd0);
    tick();

    // Back-to-back fetches, 3 cycles each.
    do_fetch(32'h8000_0000, 1'b0, cyc);
    check("issue_interval0", 32'(cyc + 1), 32'd3);
    tick();
    do_fetch(32'h8000_0004, 1'b0, cyc);
    check("issue_interval1", 32'(cyc + 1), 32'd3);
    tick();
    do_fetch(32'h8000_0008, 1'b0, cyc);

    // IDU backpressure for 5 cycles.
    idu_allowin = 1'b0;
    held_inst   = ifu_to_idu_inst;
    for (int i = 0; i < 5; i++) begin
      tick();
      check("stall_valid", 32'(ifu_to_idu_valid), 32'd1);
      check("stall_pc", ifu_to_idu_pc, 32'h8000_0008);
      check("stall_inst", ifu_to_idu_inst, held_inst);
      check("stall_arvalid", 32'(ifu_arvalid), 32'd0);
    end
    idu_allowin = 1'b1;
    tick();
    check("release_araddr", ifu_araddr, 32'h8000_000C);
    do_fetch(32'h8000_000C, 1'b0, cyc);

    // Redirect while AR is stalled by the slave.
    ar_stall_cfg = 3;
    tick();
    check("ar_stall_arvalid", 32'(ifu_arvalid), 32'd1);
    exu_redirect_valid = 1'b1;
    exu_redirect_pc    = 32'h8000_0100;
    tick();
    exu_redirect_valid = 1'b0;
    n = 0;
    while (!ifu_rready && n < 20) begin
      check("ar_hold_araddr", ifu_araddr, 32'h8000_0010);
      tick();
      n++;
    end
    check("ar_handshake", 32'(ifu_rready), 32'd1);
    ar_stall_cfg = 0;
    wait_next_ar("redir_ar", 32'h8000_0100);
    do_fetch(32'h8000_0100, 1'b0, cyc);

    // Redirect in HOLD together with idu_allowin.
    exu_redirect_valid = 1'b1;
    exu_redirect_pc    = 32'h8000_0400;
    #1;
    check("hold_redir_valid", 32'(ifu_to_idu_valid), 32'd0);
    tick();
    exu_redirect_valid = 1'b0;
    check("hold_redir_araddr", ifu_araddr, 32'h8000_0400);
    do_fetch(32'h8000_0400, 1'b0, cyc);

    // Two redirects while waiting for R; the last one wins.
    r_stall_cfg = 4;
    tick();
    check("r_test_araddr", ifu_araddr, 32'h8000_0404);
    tick();
    check("r_test_rready", 32'(ifu_rready), 32'd1);
    exu_redirect_valid = 1'b1;
    exu_redirect_pc    = 32'h8000_0200;
    tick();
    exu_redirect_valid = 1'b0;
    tick();
    exu_redirect_valid = 1'b1;
    exu_redirect_pc    = 32'h8000_0300;
    tick();
    exu_redirect_valid = 1'b0;
    r_stall_cfg = 0;
    wait_next_ar("redir_r", 32'h8000_0300);
    do_fetch(32'h8000_0300, 1'b0, cyc);

    // Error response, then OKAY.
    tick();
    resp_cfg = 2'b10;
    do_fetch(32'h8000_0304, 1'b1, cyc);
    resp_cfg = 2'b00;
    tick();
    do_fetch(32'h8000_0308, 1'b0, cyc);

    // Asynchronous reset while in R.
    r_stall_cfg = 3;
    tick();
    tick();
    check("pre_reset_rready", 32'(ifu_rready), 32'd1);
    #2;
    rst = 1'b0;
    #1;
    check_reset_values("async_reset");
    r_stall_cfg = 0;
    tick();
    rst = 1'b1;
    tick();
    do_fetch(RST_PC, 1'b0, cyc);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule
